// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8N1/8N2 frames LSB-first, optional even parity via UART_TX_PARITY_EN
//   clk, rstn (sync, active-low); tx_data/tx_valid/tx_ready byte handshake;
//   tx serial line (idle high); tx_busy = !tx_ready; tx_done pulses as the last stop bit ends.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic par_q, par_d, tx_q, tx_d, done_q, done_d, bit_end;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d = par_q;
    bit_d = bit_q;
    done_d = 1'b0;
    bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (tx_valid) begin
        shreg_d = tx_data;
        par_d = ^tx_data;
        bit_d = '0;
        state_d = START;
      end
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        bit_d = bit_q + 1'b1;
        state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
      end
      PARITY: state_d = bit_end ? STOP : PARITY;
      STOP: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'(STOP_BITS - 1)) begin
          bit_d = '0;
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA) ? shreg_d[0] :
           (state_d == PARITY) ? par_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      par_q <= par_d;
      tx_q <= tx_d;
      done_q <= done_d;
    end
  end
  assign tx_ready = state_q == IDLE;
  assign tx_busy = !tx_ready;
  assign tx = tx_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed plus random frames checked against a bit-list model of the UART frame
module tb_uart_tx;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int NB = 10 + PB + SB - 1;
  logic clk = 1'b0, rstn = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx, tx_busy, tx_done;
  int tests = 0, fails = 0;
  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[3'(k - 1)];
    if (PB == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", tx_busy, 0);
      chk("idle_done", tx_done, 0);
    end
  endtask
  task automatic run_frame(input logic [7:0] b, input logic keep);
    @(posedge clk);
    for (int n = 0; n < NB * C; n++) begin
      @(negedge clk);
      chk($sformatf("tx_%02h_bit%0d", b, n / C), tx, exp_bit(b, n / C));
      chk("done_low", tx_done, 0);
      chk("busy", tx_busy, 1);
      tx_data = 8'($urandom);
      if (n == 0) tx_valid = keep;
      if (n == 3 * C) begin
        tx_valid = 1'b1;
        tx_data = 8'h3C;
      end
      if (n == 3 * C + 1) tx_valid = keep;
    end
    @(negedge clk);
    chk("done_pulse", tx_done, 1);
    chk("done_ready", tx_ready, 1);
    chk("done_tx_high", tx, 1);
  endtask
  initial begin
    logic [7:0] b;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    rstn = 1'b1;
    idle(20);
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    run_frame(8'hA5, 1'b0);
    idle(2);
    tx_valid = 1'b1;
    tx_data = 8'h00;
    run_frame(8'h00, 1'b1);
    tx_data = 8'hFF;
    run_frame(8'hFF, 1'b0);
    idle(2);
    tx_valid = 1'b1;
    tx_data = 8'h81;
    @(posedge clk);
    for (int n = 0; n < 4 * C + 2; n++) begin
      @(negedge clk);
      if (n == 0) tx_valid = 1'b0;
      chk("abort_pre_tx", tx, exp_bit(8'h81, n / C));
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_ready", tx_ready, 1);
    chk("abort_done", tx_done, 0);
    rstn = 1'b1;
    idle(NB * C + 4);
    tx_valid = 1'b1;
    tx_data = 8'h81;
    run_frame(8'h81, 1'b0);
    idle(1);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      tx_valid = 1'b1;
      tx_data = b;
      run_frame(b, 1'b0);
      idle($urandom_range(1, 3));
    end
    tx_valid = 1'b1;
    tx_data = 8'h07;
    run_frame(8'h07, 1'b0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
